rhs_frame_packer: RTL and testbench

RHS_FRAME_PACKER -- requirements
Module: rhs_frame_packer

---
 rtl/rhs_frame_packer_pkg.sv | 26 ++
 rtl/rhs_frame_packer_if.sv | 16 +
 rtl/rhs_frame_sync.sv | 78 +++++++
 rtl/rhs_frame_packer.sv | 120 ++++++++++++
 tb/tb_rhs_frame_packer.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/rhs_frame_packer_pkg.sv
// Shared constants and types for the RHS frame packer.
//   HEADER_MAGIC_DEFAULT      : upper half of every frame header word
//   CHANNELS_PER_CHIP_DEFAULT : amplifier channels per chip (frame length)
//   DATA_WORDS / LAST_DATA_WORD : 32-bit words emitted per conversion
//   state_t                   : serializer FSM encoding
package rhs_frame_packer_pkg;

    localparam logic [15:0] HEADER_MAGIC_DEFAULT      = 16'hA55A;
    localparam int          CHANNELS_PER_CHIP_DEFAULT = 16;
    localparam int          DATA_WORDS                = 8;
    localparam logic [2:0]  LAST_DATA_WORD            = 3'(DATA_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_TS   = 2'd2,
        ST_DATA = 2'd3
    } state_t;

    // Word k of a held conversion: chip 2k in the low half, chip 2k+1 high.
    function automatic logic [31:0] data_word(input logic [255:0] hold,
                                              input logic [2:0]   idx);
        return hold[{idx, 5'b0} +: 32];
    endfunction

endpackage

// File: rtl/rhs_frame_packer_if.sv
// Packed output stream of the frame packer.
//   tdata  : 32-bit word
//   tvalid : word present; tdata/tlast/tvalid stay put until accepted
//   tready : sink can take the word
//   tlast  : final word of a frame
// A word transfers on a rising clock edge where tvalid and tready are both
// high; tvalid never waits on tready and is never withdrawn before transfer.
interface rhs_frame_packer_if;
    logic [31:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/rhs_frame_sync.sv
// Channel-sequence tracker: decides whether an incoming conversion starts a
// frame, continues it, is discarded, or is dropped, and keeps the drop
// counter and sticky overflow flag.
//   slot_free    : serializer can latch a conversion this cycle
//   hdr_done     : header word transferring; hdr_reported is its count field
//   take_hdr     : channel 0 accepted (new frame)
//   take_data    : next-in-sequence channel accepted
//   drop_count   : saturating count of dropped conversions
//   overflow_sticky : any drop since the last record_enable rising edge
module rhs_frame_sync #(
    parameter int CHANNELS_PER_CHIP = 16
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       record_enable,
    input  logic       sample_valid,
    input  logic [7:0] sample_channel,
    input  logic       slot_free,
    input  logic       hdr_done,
    input  logic [7:0] hdr_reported,
    output logic       take_hdr,
    output logic       take_data,
    output logic [7:0] drop_count,
    output logic       overflow_sticky
);
    logic       rec_q;
    logic       in_sync;
    logic [7:0] expected;
    logic       amp, accept, seq_drop, busy_drop, drop, rec_rise;
    logic [7:0] cnt_base;

    assign amp       = sample_valid & record_enable
                     & (sample_channel < 8'(CHANNELS_PER_CHIP));
    assign accept    = amp & slot_free;
    assign take_hdr  = accept & (sample_channel == 8'd0);
    assign take_data = accept & (sample_channel != 8'd0) & in_sync
                     & (sample_channel == expected);
    assign seq_drop  = accept & (sample_channel != 8'd0) & in_sync
                     & (sample_channel != expected);
    assign busy_drop = amp & ~slot_free;
    assign drop      = seq_drop | busy_drop;
    assign rec_rise  = record_enable & ~rec_q;

    // Drops that land while a header is stalled are not lost: the header
    // handshake only subtracts what that header actually reported.
    always_comb begin
        cnt_base = drop_count;
        if (rec_rise)
            cnt_base = 8'd0;
        else if (hdr_done)
            cnt_base = drop_count - hdr_reported;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rec_q           <= 1'b0;
            in_sync         <= 1'b0;
            expected        <= 8'd0;
            drop_count      <= 8'd0;
            overflow_sticky <= 1'b0;
        end else begin
            rec_q <= record_enable;
            if (take_hdr) begin
                in_sync  <= 1'b1;
                expected <= 8'd1;
            end else if (take_data) begin
                expected <= expected + 8'd1;
            end else if (drop || !record_enable) begin
                in_sync <= 1'b0;
            end
            drop_count <= (drop && cnt_base != 8'hFF) ? cnt_base + 8'd1 : cnt_base;
            if (drop)
                overflow_sticky <= 1'b1;
            else if (rec_rise)
                overflow_sticky <= 1'b0;
        end
    end
endmodule

// File: rtl/rhs_frame_packer.sv
// Packs 256-bit multi-chip conversions into a 32-bit stream.
// Channel 0 emits HDR, TS, then 8 DATA words; later channels emit 8 DATA words.
//   clk, rstn        : clock, asynchronous active-low reset
//   record_enable    : accept conversions when high; clears timestamp when low
//   sample_valid/_channel/_data : one conversion of all 16 chips
//   m                : output stream (master side)
//   busy             : a conversion is held or being emitted
//   overflow_sticky  : a conversion was dropped
//   fsm_state        : serializer state, for observation
module rhs_frame_packer
    import rhs_frame_packer_pkg::*;
#(
    parameter logic [15:0] HEADER_MAGIC      = HEADER_MAGIC_DEFAULT,
    parameter int          CHANNELS_PER_CHIP = CHANNELS_PER_CHIP_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      record_enable,
    input  logic                      sample_valid,
    input  logic [7:0]                sample_channel,
    input  logic [255:0]              sample_data,
    rhs_frame_packer_if.master        m,
    output logic                      busy,
    output logic                      overflow_sticky,
    output state_t                    fsm_state
);
    state_t       state;
    logic [2:0]   idx;
    logic [255:0] hold;
    logic [31:0]  ts_hold;
    logic [31:0]  frame_cnt;
    logic         last_ch;
    logic         hs, slot_free, hdr_done;
    logic         take_hdr, take_data;
    logic [7:0]   drop_count;

    assign hs        = m.tvalid & m.tready;
    // A new conversion may replace the last DATA word in the cycle it leaves.
    assign slot_free = (state == ST_IDLE)
                     | ((state == ST_DATA) & (idx == LAST_DATA_WORD) & hs);
    assign hdr_done  = (state == ST_HDR) & hs;
    assign busy      = (state != ST_IDLE);
    assign fsm_state = state;

    rhs_frame_sync #(.CHANNELS_PER_CHIP(CHANNELS_PER_CHIP)) u_sync (
        .clk             (clk),
        .rstn            (rstn),
        .record_enable   (record_enable),
        .sample_valid    (sample_valid),
        .sample_channel  (sample_channel),
        .slot_free       (slot_free),
        .hdr_done        (hdr_done),
        .hdr_reported    (m.tdata[7:0]),
        .take_hdr        (take_hdr),
        .take_data       (take_data),
        .drop_count      (drop_count),
        .overflow_sticky (overflow_sticky)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            idx       <= 3'd0;
            hold      <= '0;
            ts_hold   <= 32'd0;
            frame_cnt <= 32'd0;
            last_ch   <= 1'b0;
            m.tdata   <= 32'd0;
            m.tvalid  <= 1'b0;
            m.tlast   <= 1'b0;
        end else begin
            if (!record_enable)
                frame_cnt <= 32'd0;
            else if (take_hdr)
                frame_cnt <= frame_cnt + 32'd1;

            if (take_hdr) begin
                state    <= ST_HDR;
                hold     <= sample_data;
                ts_hold  <= frame_cnt;
                last_ch  <= (sample_channel == 8'(CHANNELS_PER_CHIP - 1));
                m.tdata  <= {HEADER_MAGIC, 7'b0, overflow_sticky, drop_count};
                m.tvalid <= 1'b1;
                m.tlast  <= 1'b0;
            end else if (take_data) begin
                state    <= ST_DATA;
                idx      <= 3'd0;
                hold     <= sample_data;
                last_ch  <= (sample_channel == 8'(CHANNELS_PER_CHIP - 1));
                m.tdata  <= sample_data[31:0];
                m.tvalid <= 1'b1;
                m.tlast  <= 1'b0;
            end else if (hs) begin
                case (state)
                    ST_HDR: begin
                        state   <= ST_TS;
                        m.tdata <= ts_hold;
                    end
                    ST_TS: begin
                        state   <= ST_DATA;
                        idx     <= 3'd0;
                        m.tdata <= data_word(hold, 3'd0);
                    end
                    ST_DATA: begin
                        if (idx == LAST_DATA_WORD) begin
                            state    <= ST_IDLE;
                            m.tvalid <= 1'b0;
                            m.tlast  <= 1'b0;
                        end else begin
                            idx     <= idx + 3'd1;
                            m.tdata <= data_word(hold, idx + 3'd1);
                            m.tlast <= last_ch && ((idx + 3'd1) == LAST_DATA_WORD);
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rhs_frame_packer.sv
module tb_rhs_frame_packer;
    import rhs_frame_packer_pkg::*;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         record_enable = 1'b0;
    logic         sample_valid = 1'b0;
    logic [7:0]   sample_channel = 8'd0;
    logic [255:0] sample_data = '0;
    logic         busy, overflow_sticky;
    state_t       fsm_state;
    logic         rec_next = 1'b0;

    rhs_frame_packer_if bus ();

    rhs_frame_packer dut (
        .clk             (clk),
        .rstn            (rstn),
        .record_enable   (record_enable),
        .sample_valid    (sample_valid),
        .sample_channel  (sample_channel),
        .sample_data     (sample_data),
        .m               (bus),
        .busy            (busy),
        .overflow_sticky (overflow_sticky),
        .fsm_state       (fsm_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: the stream of words still owed, tagged {hdr, last, data}.
    logic [33:0] exp_q[$];
    logic [32:0] got_q[$];
    bit          m_in_sync;
    int          m_exp;
    int          m_cnt;
    bit          m_sticky;
    logic [31:0] m_frame;
    bit          m_prev_rec;

    task automatic model_reset();
        exp_q.delete();
        m_in_sync  = 0;
        m_exp      = 0;
        m_cnt      = 0;
        m_sticky   = 0;
        m_frame    = 32'd0;
        m_prev_rec = record_enable;
    endtask

    task automatic push_data(input logic [255:0] d, input bit last_conv);
        for (int k = 0; k < 8; k++)
            exp_q.push_back({1'b0, last_conv && (k == 7), d[32*k +: 32]});
    endtask

    task automatic model_step(input bit rdy, input bit vld, input logic [7:0] ch,
                              input logic [255:0] d);
        bit transfer, free, amp, drop, rise;
        int pend;
        pend     = exp_q.size();
        transfer = (pend > 0) && rdy;
        check("busy", busy, pend > 0);
        check("sticky", overflow_sticky, m_sticky);
        if (pend > 0) begin
            check("tvalid", bus.tvalid, 1);
            check("tdata", bus.tdata, exp_q[0][31:0]);
            check("tlast", bus.tlast, exp_q[0][32]);
        end else begin
            check("tvalid_idle", bus.tvalid, 0);
        end
        if (transfer) begin
            got_q.push_back({bus.tlast, bus.tdata});
            if (exp_q[0][33]) m_cnt = m_cnt - int'(exp_q[0][7:0]);
            void'(exp_q.pop_front());
        end
        rise = record_enable && !m_prev_rec;
        amp  = record_enable && vld && (ch < 16);
        free = (pend == 0) || (pend == 1 && transfer);
        drop = 0;
        if (amp && free) begin
            if (ch == 0) begin
                exp_q.push_back({1'b1, 1'b0, 16'hA55A, 7'b0, m_sticky, 8'(m_cnt)});
                exp_q.push_back({2'b00, m_frame});
                push_data(d, 1'b0);
                m_in_sync = 1;
                m_exp     = 1;
                m_frame   = m_frame + 32'd1;
            end else if (m_in_sync && ch == m_exp) begin
                push_data(d, ch == 15);
                m_exp++;
            end else if (m_in_sync) begin
                drop = 1;
                m_in_sync = 0;
            end
        end else if (amp) begin
            drop = 1;
            m_in_sync = 0;
        end
        if (!record_enable) begin
            m_in_sync = 0;
            m_frame   = 32'd0;
        end
        if (rise) m_cnt = 0;
        if (drop) begin
            if (m_cnt < 255) m_cnt++;
            m_sticky = 1;
        end else if (rise) begin
            m_sticky = 0;
        end
        m_prev_rec = record_enable;
    endtask

    task automatic cycle(input bit rdy, input bit vld, input logic [7:0] ch,
                         input logic [255:0] d);
        @(negedge clk);
        record_enable  = rec_next;
        bus.tready     = rdy;
        sample_valid   = vld;
        sample_channel = ch;
        sample_data    = d;
        model_step(rdy, vld, ch, d);
    endtask

    task automatic do_reset();
        @(negedge clk);
        sample_valid = 1'b0;
        bus.tready   = 1'b0;
        rstn         = 1'b0;
        #1;
        check("rst_tvalid", bus.tvalid, 0);
        check("rst_tlast", bus.tlast, 0);
        check("rst_tdata", bus.tdata, 0);
        check("rst_busy", busy, 0);
        check("rst_sticky", overflow_sticky, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        m_prev_rec = record_enable;
    endtask

    task automatic send(input logic [7:0] ch, input logic [255:0] d);
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() <= 1) begin
                cycle(1, 1, ch, d);
                return;
            end
            cycle(1, 0, 8'd0, '0);
        end
        check("send_timeout", exp_q.size(), 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) return;
            cycle(1, 0, 8'd0, '0);
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    function automatic logic [255:0] pat();
        logic [255:0] r;
        for (int c = 0; c < 16; c++) r[16*c +: 16] = 16'h00C0 + 16'(c);
        return r;
    endfunction

    function automatic logic [255:0] rnd256();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[32*k +: 32] = $urandom;
        return r;
    endfunction

    initial begin
        int tl_count, tl_pos, nxt;
        bus.tready = 1'b0;
        model_reset();
        do_reset();

        // Full frame, channels 0..15, sink always ready.
        rec_next = 1'b1;
        cycle(1, 0, 8'd0, '0);
        got_q.delete();
        for (int ch = 0; ch < 16; ch++) send(8'(ch), pat());
        drain();
        check("frame_len", got_q.size(), 130);
        check("frame_hdr", got_q[0], 33'h0_A55A_0000);
        check("frame_ts", got_q[1], 33'h0);
        check("frame_d0", got_q[2], 33'h0_00C1_00C0);
        tl_count = 0;
        tl_pos = -1;
        foreach (got_q[i]) if (got_q[i][32]) begin tl_count++; tl_pos = i; end
        check("tlast_count", tl_count, 1);
        check("tlast_pos", tl_pos, 129);

        // Sequence 0,1,3,4,0.
        do_reset();
        cycle(1, 0, 8'd0, '0);
        got_q.delete();
        send(8'd0, rnd256());
        send(8'd1, rnd256());
        send(8'd3, rnd256());
        send(8'd4, rnd256());
        send(8'd0, rnd256());
        drain();
        check("seq_len", got_q.size(), 28);
        check("seq_hdr2_low", got_q[18][15:0], 16'h0101);
        check("seq_ts2", got_q[19], 33'h1);

        // Header stall with a channel-1 arrival during the stall.
        do_reset();
        cycle(1, 0, 8'd0, '0);
        got_q.delete();
        send(8'd0, pat());
        for (int i = 0; i < 20; i++) cycle(0, i == 5, 8'd1, pat());
        drain();
        check("stall_sticky", overflow_sticky, 1);
        send(8'd0, pat());
        drain();
        check("stall_hdr1", got_q[0], 33'h0_A55A_0000);
        check("stall_hdr2", got_q[10], 33'h0_A55A_0101);

        // Reset in the middle of DATA.
        send(8'd0, rnd256());
        repeat (4) cycle(1, 0, 8'd0, '0);
        do_reset();
        cycle(1, 0, 8'd0, '0);
        got_q.delete();
        send(8'd0, rnd256());
        drain();
        check("rst_ts", got_q[1], 33'h0);

        // record_enable toggle after three frames; non-amplifier slots.
        for (int f = 0; f < 3; f++) begin
            send(8'd0, rnd256());
            send(8'd1, rnd256());
            drain();
        end
        rec_next = 1'b0;
        repeat (3) cycle(1, 0, 8'd0, '0);
        rec_next = 1'b1;
        repeat (2) cycle(1, 0, 8'd0, '0);
        got_q.delete();
        for (int ch = 16; ch < 19; ch++) cycle(1, 1, 8'(ch), rnd256());
        repeat (3) cycle(1, 0, 8'd0, '0);
        check("nonamp_quiet", got_q.size(), 0);
        send(8'd0, rnd256());
        drain();
        check("reen_hdr", got_q[0], 33'h0_A55A_0000);
        check("reen_ts", got_q[1], 33'h0);

        // Randomized traffic.
        nxt = 0;
        for (int i = 0; i < 4000; i++) begin
            bit vld;
            logic [7:0] ch;
            if ($urandom_range(0, 199) == 0) rec_next = ~rec_next;
            vld = ($urandom_range(0, 3) == 0);
            ch  = ($urandom_range(0, 9) < 8) ? 8'(nxt) : 8'($urandom_range(0, 19));
            if (vld && ch < 16) nxt = (ch + 1) % 16;
            cycle($urandom_range(0, 3) != 0, vld, ch, rnd256());
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
